// File: rtl/i2c_slave_regs.sv
// I2C target bridging bus transactions onto an 8-bit register bus.
//
// Write: addr+W, subaddress, data byte(s), STOP.
// Read : addr+W, subaddress, repeated START (or STOP/START), addr+R,
//        data byte(s), master NACK, STOP.
//
// Ports:
//   sys_clock  system clock
//   reset      asynchronous active-high reset
//   SDA        open-drain data (driven 1'b0 or released to 1'bz)
//   SCL        bus clock (never stretched)
//   reg_addr   register pointer, loaded from the subaddress
//   reg_wdata  last received write byte
//   reg_we     one-cycle write strobe
//   reg_re     one-cycle read request; reg_rdata valid the cycle after
//   reg_rdata  register read data
//   addressed  high from own-address match until START/STOP
module i2c_slave_regs #(
    parameter logic [6:0] slave_addr = 7'h4C,
    parameter int         freq       = 66,
    parameter int         t_hold     = (freq >> 1) + 1
) (
    input  logic       sys_clock,
    input  logic       reset,
    inout  wire        SDA,
    input  logic       SCL,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       addressed
);
    localparam int HW = $clog2(t_hold + 1);

    typedef enum logic [2:0] {IDLE, ADDR, SUB, WR, RD, IGNORE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sda_sh_q, scl_sh_q;
    logic          sda_f_q, scl_f_q, sda_fd_q, scl_fd_q;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          ack_ph_q, ack_ph_d;
    logic          ack_q, ack_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic          re_dly_q;
    logic          addressed_q, addressed_d;
    logic          oe_q, oe_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          hold_act_q, hold_act_d;

    logic          scl_rise, scl_fall, start_c, stop_c, drive_c;
    logic [7:0]    byte_c;

    // Glitch filter: filtered level moves only when 4 consecutive samples agree.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            sda_sh_q <= 4'hF;
            scl_sh_q <= 4'hF;
            sda_f_q  <= 1'b1;
            scl_f_q  <= 1'b1;
            sda_fd_q <= 1'b1;
            scl_fd_q <= 1'b1;
        end else begin
            sda_sh_q <= {sda_sh_q[2:0], SDA};
            scl_sh_q <= {scl_sh_q[2:0], SCL};
            if (&sda_sh_q)       sda_f_q <= 1'b1;
            else if (~|sda_sh_q) sda_f_q <= 1'b0;
            if (&scl_sh_q)       scl_f_q <= 1'b1;
            else if (~|scl_sh_q) scl_f_q <= 1'b0;
            sda_fd_q <= sda_f_q;
            scl_fd_q <= scl_f_q;
        end
    end

    assign scl_rise = scl_f_q & ~scl_fd_q;
    assign scl_fall = ~scl_f_q & scl_fd_q;
    assign start_c  = scl_f_q & scl_fd_q & sda_fd_q & ~sda_f_q;
    assign stop_c   = scl_f_q & scl_fd_q & ~sda_fd_q & sda_f_q;
    assign byte_c   = {rx_q[6:0], sda_f_q};

    // Level SDA should take once the hold delay after an SCL fall expires.
    always_comb begin
        drive_c = 1'b0;
        case (state_q)
            ADDR, SUB, WR: drive_c = ack_ph_q & ack_q;
            RD:            drive_c = (bit_cnt_q < 4'd8) & ~tx_q[7];
            default:       drive_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ack_ph_d    = ack_ph_q;
        ack_d       = ack_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        addressed_d = addressed_q;
        oe_d        = oe_q;
        hold_cnt_d  = hold_cnt_q;
        hold_act_d  = hold_act_q;

        if (re_dly_q) tx_d = reg_rdata;

        if (hold_act_q) begin
            if (hold_cnt_q <= HW'(1)) begin
                hold_act_d = 1'b0;
                oe_d       = drive_c;
            end else begin
                hold_cnt_d = hold_cnt_q - HW'(1);
            end
        end

        if (start_c || stop_c) begin
            state_d     = start_c ? ADDR : IDLE;
            bit_cnt_d   = 4'd0;
            ack_ph_d    = 1'b0;
            ack_d       = 1'b0;
            oe_d        = 1'b0;
            hold_act_d  = 1'b0;
            addressed_d = 1'b0;
        end else if (state_q inside {ADDR, SUB, WR, RD}) begin
            if (scl_fall) begin
                hold_cnt_d = HW'(t_hold);
                hold_act_d = 1'b1;
            end
            if (scl_rise && bit_cnt_q < 4'd8) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                rx_d      = byte_c;
                if (state_q == RD) tx_d = {tx_q[6:0], 1'b1};
                if (bit_cnt_q == 4'd7) begin
                    case (state_q)
                        ADDR: begin
                            if (byte_c[7:1] == slave_addr) begin
                                ack_d       = 1'b1;
                                addressed_d = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                        SUB: ack_d = 1'b1;
                        WR: begin
                            ack_d   = 1'b1;
                            wdata_d = byte_c;
                            we_d    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (scl_rise && ack_ph_q && state_q == RD) begin
                ack_d = ~sda_f_q;
            end else if (scl_fall && bit_cnt_q == 4'd8 && !ack_ph_q) begin
                ack_ph_d = 1'b1;
            end else if (scl_fall && ack_ph_q) begin
                // End of the ninth clock: close the byte and move on.
                ack_ph_d  = 1'b0;
                ack_d     = 1'b0;
                bit_cnt_d = 4'd0;
                case (state_q)
                    ADDR: begin
                        if (rx_q[0]) begin
                            state_d = RD;
                            re_d    = 1'b1;
                        end else begin
                            state_d = SUB;
                        end
                    end
                    SUB: begin
                        addr_d  = rx_q;
                        state_d = WR;
                    end
                    WR: addr_d = addr_q + 8'd1;
                    RD: begin
                        addr_d = addr_q + 8'd1;
                        if (ack_q) re_d = 1'b1;
                        else       state_d = IGNORE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            ack_ph_q    <= 1'b0;
            ack_q       <= 1'b0;
            rx_q        <= 8'h00;
            tx_q        <= 8'hFF;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            re_dly_q    <= 1'b0;
            addressed_q <= 1'b0;
            oe_q        <= 1'b0;
            hold_cnt_q  <= '0;
            hold_act_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ack_ph_q    <= ack_ph_d;
            ack_q       <= ack_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            re_dly_q    <= re_q;
            addressed_q <= addressed_d;
            oe_q        <= oe_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_act_q  <= hold_act_d;
        end
    end

    assign SDA       = oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign addressed = addressed_q;
endmodule
